// File: rtl/i2c_cfg_seq.sv
// I2C register-table loader: fetches NUM_ENTRIES words and writes each to one slave as a write frame.
// Optional macro I2C_CLK_STRETCH_EN: honour slave clock stretching during the SCL-high phase.
module i2c_cfg_seq #(
  parameter int         CLK_FREQ      = 50000000,
  parameter int         I2C_FREQ      = 100000,
  parameter logic [6:0] DEV_ADDR      = 7'h1A,
  parameter int         NUM_ENTRIES   = 10,
  parameter int         PAYLOAD_BYTES = 2,
  parameter int         RETRY_MAX     = 3,
  parameter int         GAP_TICKS     = 4,
  parameter int         AUTO_START    = 1
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic                         iSTART,
  output logic [7:0]                   oTBL_IDX,
  input  logic [8*PAYLOAD_BYTES-1:0]   iTBL_DATA,
  inout  wire                          ioSCL,
  inout  wire                          ioSDA,
  output logic                         oBUSY,
  output logic                         oDONE,
  output logic                         oERR,
  output logic [7:0]                   oERR_IDX
);

  localparam int Q_RAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int Q     = (Q_RAW < 2) ? 2 : Q_RAW;
  localparam int CW    = $clog2(Q);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  logic [2:0]                 r_state;
  logic [1:0]                 r_phase;
  logic [CW-1:0]              r_tcnt;
  logic                       r_scl_low;
  logic                       r_sda_low;
  logic                       r_auto;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_err;
  logic [7:0]                 r_idx;
  logic [7:0]                 r_err_idx;
  logic [7:0]                 r_retry;
  logic                       r_fcnt;
  logic [8*PAYLOAD_BYTES-1:0] r_data;
  logic [6:0]                 r_shift;
  logic [2:0]                 r_bit;
  logic [2:0]                 r_byte;
  logic                       r_ack_sda;
  logic                       r_nack;
  logic [15:0]                r_gap;
  logic                       w_tick;
  logic                       w_stretch;
  logic [7:0]                 w_next_byte;

  assign ioSCL    = r_scl_low ? 1'b0 : 1'bz;
  assign ioSDA    = r_sda_low ? 1'b0 : 1'bz;
  assign oTBL_IDX = r_idx;
  assign oBUSY    = r_busy;
  assign oDONE    = r_done;
  assign oERR     = r_err;
  assign oERR_IDX = r_err_idx;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low after release freezes the quarter-bit timer at 0.
  assign w_stretch = !r_scl_low && (r_phase == 2'd2) && !ioSCL &&
                     ((r_state == S_START) || (r_state == S_SHIFT) ||
                      (r_state == S_ACK) || (r_state == S_STOP));
`else
  assign w_stretch = 1'b0 & ioSCL;
`endif

  assign w_tick = (r_tcnt == CW'(Q - 1)) && !w_stretch;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_tcnt <= '0;
    end else if (w_stretch || (r_tcnt == CW'(Q - 1))) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + CW'(1);
    end
  end

  // Data byte following r_byte; byte 0 of a frame is the address, so data byte k is word byte k-1.
  always_comb begin
    w_next_byte = 8'h00;
    for (int k = 1; k <= PAYLOAD_BYTES; k++) begin
      if ((r_byte + 3'd1) == 3'(k)) w_next_byte = r_data[8*(PAYLOAD_BYTES-k) +: 8];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= S_IDLE;
      r_phase   <= 2'd0;
      r_scl_low <= 1'b0;
      r_sda_low <= 1'b0;
      r_auto    <= (AUTO_START != 0);
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= 8'd0;
      r_err_idx <= 8'd0;
      r_retry   <= 8'd0;
      r_fcnt    <= 1'b0;
      r_data    <= '0;
      r_shift   <= 7'd0;
      r_bit     <= 3'd0;
      r_byte    <= 3'd0;
      r_ack_sda <= 1'b0;
      r_nack    <= 1'b0;
      r_gap     <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_scl_low <= 1'b0;
          r_sda_low <= 1'b0;
          if (iSTART || r_auto) begin
            r_auto  <= 1'b0;
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= 8'd0;
            r_retry <= 8'd0;
            r_fcnt  <= 1'b0;
          end
        end
        // Two cycles after the index moves, so a registered ROM has settled.
        S_FETCH: begin
          if (r_fcnt) begin
            r_data  <= iTBL_DATA;
            r_nack  <= 1'b0;
            r_phase <= 2'd0;
            r_state <= S_START;
          end else begin
            r_fcnt <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              2'd0: r_sda_low <= 1'b1;
              2'd2: r_scl_low <= 1'b1;
              2'd3: begin
                r_state   <= S_SHIFT;
                r_byte    <= 3'd0;
                r_bit     <= 3'd0;
                r_shift   <= {DEV_ADDR[5:0], 1'b0};
                r_sda_low <= ~DEV_ADDR[6];
              end
              default: ;
            endcase
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              2'd1: r_scl_low <= 1'b0;
              2'd3: begin
                r_scl_low <= 1'b1;
                if (r_bit == 3'd7) begin
                  r_state   <= S_ACK;
                  r_sda_low <= 1'b0;
                end else begin
                  r_bit     <= r_bit + 3'd1;
                  r_shift   <= {r_shift[5:0], 1'b0};
                  r_sda_low <= ~r_shift[6];
                end
              end
              default: ;
            endcase
          end
        end
        S_ACK: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              2'd1: r_scl_low <= 1'b0;
              2'd2: r_ack_sda <= ioSDA;
              2'd3: begin
                r_scl_low <= 1'b1;
                if (r_ack_sda || (r_byte == 3'(PAYLOAD_BYTES))) begin
                  r_nack    <= r_ack_sda;
                  r_state   <= S_STOP;
                  r_sda_low <= 1'b1;
                end else begin
                  r_state   <= S_SHIFT;
                  r_byte    <= r_byte + 3'd1;
                  r_bit     <= 3'd0;
                  r_shift   <= w_next_byte[6:0];
                  r_sda_low <= ~w_next_byte[7];
                end
              end
              default: ;
            endcase
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              2'd1: r_scl_low <= 1'b0;
              2'd2: r_sda_low <= 1'b0;
              2'd3: begin
                r_state <= S_GAP;
                r_gap   <= 16'd0;
              end
              default: ;
            endcase
          end
        end
        S_GAP: begin
          if (r_gap >= 16'(GAP_TICKS)) begin
            if (r_nack && (r_retry < 8'(RETRY_MAX))) begin
              r_retry <= r_retry + 8'd1;
              r_nack  <= 1'b0;
              r_phase <= 2'd0;
              r_state <= S_START;
            end else if (r_nack) begin
              r_err     <= 1'b1;
              r_err_idx <= r_idx;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else if (r_idx == 8'(NUM_ENTRIES - 1)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 8'd1;
              r_retry <= 8'd0;
              r_fcnt  <= 1'b0;
              r_state <= S_FETCH;
            end
          end else if (w_tick) begin
            r_gap <= r_gap + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
